// File: rtl/pipe_exmem_reg.sv
// Y86-64 execute->memory pipeline register: bubble insertion, stall hold and sticky exception squash.
// Optional performance counters are built when PIPE_EXMEM_PERF_EN is defined.

module pipe_exmem_reg #(
    parameter int unsigned DATA_W = 64
`ifdef PIPE_EXMEM_PERF_EN
    , parameter int unsigned CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              M_stall,
    input  logic              M_bubble,
    input  logic [2:0]        e_stat,
    input  logic [3:0]        e_icode,
    input  logic              e_Cnd,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [DATA_W-1:0] e_valA,
    input  logic [3:0]        e_dstE,
    input  logic [3:0]        e_dstM,
    input  logic [2:0]        m_stat,
    input  logic [2:0]        W_stat,
    output logic [2:0]        M_stat,
    output logic [3:0]        M_icode,
    output logic              M_Cnd,
    output logic [DATA_W-1:0] M_valE,
    output logic [DATA_W-1:0] M_valA,
    output logic [3:0]        M_dstE,
    output logic [3:0]        M_dstM,
    output logic              M_halted
`ifdef PIPE_EXMEM_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_bubbles,
    output logic [CNT_W-1:0]  perf_stalls,
    output logic [CNT_W-1:0]  perf_cycles
`endif
);

    localparam int unsigned STAT_W  = 3;
    localparam int unsigned ICODE_W = 4;
    localparam int unsigned REG_W   = 4;

    localparam logic [STAT_W-1:0]  STAT_AOK   = STAT_W'(1);
    localparam logic [STAT_W-1:0]  STAT_HLT   = STAT_W'(2);
    localparam logic [STAT_W-1:0]  STAT_ADR   = STAT_W'(3);
    localparam logic [STAT_W-1:0]  STAT_INS   = STAT_W'(4);
    localparam logic [ICODE_W-1:0] ICODE_NOP  = ICODE_W'(4'h1);
    localparam logic [ICODE_W-1:0] ICODE_CMOV = ICODE_W'(4'h2);
    localparam logic [REG_W-1:0]   REG_NONE   = REG_W'(4'hF);

    logic [STAT_W-1:0]  stat_q,  stat_d;
    logic [ICODE_W-1:0] icode_q, icode_d;
    logic               cnd_q,   cnd_d;
    logic [DATA_W-1:0]  vale_q,  vale_d;
    logic [DATA_W-1:0]  vala_q,  vala_d;
    logic [REG_W-1:0]   dste_q,  dste_d;
    logic [REG_W-1:0]   dstm_q,  dstm_d;
    logic               halted_q, halted_d;
    logic               exc_c;

    function automatic logic is_exc(input logic [STAT_W-1:0] s);
        return (s == STAT_HLT) || (s == STAT_ADR) || (s == STAT_INS);
    endfunction

    assign exc_c = is_exc(m_stat) || is_exc(W_stat);

    // Squash dominates stall; stall dominates bubble; otherwise capture execute results.
    always_comb begin
        stat_d   = stat_q;
        icode_d  = icode_q;
        cnd_d    = cnd_q;
        vale_d   = vale_q;
        vala_d   = vala_q;
        dste_d   = dste_q;
        dstm_d   = dstm_q;
        halted_d = halted_q;
        if (halted_q || exc_c) begin
            stat_d   = STAT_AOK;
            icode_d  = ICODE_NOP;
            cnd_d    = 1'b0;
            vale_d   = '0;
            vala_d   = '0;
            dste_d   = REG_NONE;
            dstm_d   = REG_NONE;
            halted_d = 1'b1;
        end else if (M_stall) begin
            halted_d = halted_q;
        end else if (M_bubble) begin
            stat_d  = STAT_AOK;
            icode_d = ICODE_NOP;
            cnd_d   = 1'b0;
            vale_d  = '0;
            vala_d  = '0;
            dste_d  = REG_NONE;
            dstm_d  = REG_NONE;
        end else begin
            stat_d  = e_stat;
            icode_d = e_icode;
            cnd_d   = e_Cnd;
            vale_d  = e_valE;
            vala_d  = e_valA;
            dste_d  = ((e_icode == ICODE_CMOV) && !e_Cnd) ? REG_NONE : e_dstE;
            dstm_d  = e_dstM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q   <= STAT_AOK;
            icode_q  <= ICODE_NOP;
            cnd_q    <= 1'b0;
            vale_q   <= '0;
            vala_q   <= '0;
            dste_q   <= REG_NONE;
            dstm_q   <= REG_NONE;
            halted_q <= 1'b0;
        end else begin
            stat_q   <= stat_d;
            icode_q  <= icode_d;
            cnd_q    <= cnd_d;
            vale_q   <= vale_d;
            vala_q   <= vala_d;
            dste_q   <= dste_d;
            dstm_q   <= dstm_d;
            halted_q <= halted_d;
        end
    end

    assign M_stat   = stat_q;
    assign M_icode  = icode_q;
    assign M_Cnd    = cnd_q;
    assign M_valE   = vale_q;
    assign M_valA   = vala_q;
    assign M_dstE   = dste_q;
    assign M_dstM   = dstm_q;
    assign M_halted = halted_q;

`ifdef PIPE_EXMEM_PERF_EN
    logic [CNT_W-1:0] bub_q, bub_d;
    logic [CNT_W-1:0] stl_q, stl_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             bubble_edge_c;
    logic             stall_edge_c;

    assign bubble_edge_c = halted_q || exc_c || (!M_stall && M_bubble);
    assign stall_edge_c  = !(halted_q || exc_c) && M_stall;

    // Saturating event counters.
    always_comb begin
        cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
        bub_d = bub_q;
        stl_d = stl_q;
        if (bubble_edge_c && (bub_q != '1)) begin
            bub_d = bub_q + CNT_W'(1);
        end
        if (stall_edge_c && (stl_q != '1)) begin
            stl_d = stl_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bub_q <= '0;
            stl_q <= '0;
            cyc_q <= '0;
        end else begin
            bub_q <= bub_d;
            stl_q <= stl_d;
            cyc_q <= cyc_d;
        end
    end

    assign perf_bubbles = bub_q;
    assign perf_stalls  = stl_q;
    assign perf_cycles  = cyc_q;
`endif

endmodule
